fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- Fetch sequencer that owns the program counter and feeds instructions from instruction memory (imem) to decode.
- Issues one request/acknowledge fetch per instruction and holds the fetched word until decode consumes it.
- On consumption, applies the next-PC selection (sequential, branch, jump, register jump) to the consumed instruction's PC, then starts the next fetch.

Parameters:
- RESET_PC, 32'h0000_3000: PC loaded on reset.
- TIMEOUT, 16: fetch-wait cycles without imem_ack before fetch_err sets; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- npcop  in  2  next-PC select for the instruction being consumed.
- imm16  in  16  branch offset (word units, signed).
- imm26  in  26  jump index.
- jr_target  in  32  register-jump target.
- stall  in  1  decode cannot accept the presented instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ack  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched word.
- inst_valid  out  1  inst/inst_pc valid for decode.
- inst  out  32  held instruction.
- inst_pc  out  32  address of inst.
- inst_count  out  32  number of consumed instructions.
- fetch_err  out  1  sticky: a fetch waited TIMEOUT cycles.
- addr_err  out  1  sticky: a misaligned next PC was produced.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Registers: state=S_RST, pc=RESET_PC, inst=0, inst_pc=RESET_PC, inst_count=0, wait counter=0, fetch_err=0, addr_err=0.
  - Outputs: imem_req=0, inst_valid=0.
  - Reset mid-fetch abandons the fetch; an imem_ack in the cycle after reset is ignored.
- State S_RST: imem_req=0. Goes to S_FETCH next cycle unconditionally.
- State S_FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - imem_ack=1: inst<=imem_rdata, inst_pc<=pc, wait counter<=0, go to S_VALID.
  - No ack: wait counter increments, saturating at TIMEOUT-1. When it reaches TIMEOUT-1, fetch_err<=1. imem_req stays asserted.
  - stall, npcop and the immediates are ignored in this state.
- State S_VALID:
  - imem_req=0, inst_valid=1.
  - stall=1: everything holds.
  - stall=0 (consume): pc<=next, inst_count<=inst_count+1 (wraps mod 2^32), go to S_FETCH.
  - Minimum cost is 2 cycles per instruction when imem acknowledges in the request cycle.
  - imem_ack outside S_FETCH is ignored.
- Next-PC arithmetic (all mod 2^32, base P=inst_pc):
  - 00 SEQ: P+4.
  - 01 BR: P+4+{{14{imm16[15]}},imm16,2'b00}.
  - 10 J: {P[31:28],imm26,2'b00}.
  - 11 JR: jr_target.
  - If next[1:0]!=0 (JR only): addr_err<=1 (sticky) and pc<={next[31:2],2'b00}.
- Sticky flags clear only on reset.
- Outputs are registered, apart from combinational decode of state for imem_req and inst_valid.

Decomposition:
- Package fetch_pkg:
  - NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11.
  - State encodings S_RST, S_FETCH, S_VALID.
  - Default RESET_PC.
- Sub-module npc_target: combinational next-address calculator (pc, npcop, imm16, imm26, jr_target -> next, misaligned).
  - fetch_seq holds the FSM, registers, counters and flags.

Test Plan:
1. Reset then sequential flow:
   - Stimulus: imem acks each request in the same cycle; stall=0; npcop=00.
   - Required: imem_addr 0x3000, 0x3004, 0x3008 on successive fetches; inst_valid pulses every 2nd cycle; inst_count=3 after third consume.
2. Branch, both signs:
   - At inst_pc=0x3010 with npcop=01, imm16=0xFFFC: next fetch at 0x3004.
   - With imm16=0x0003: next fetch at 0x3020.
   - At inst_pc=0xFFFF_FFFC with SEQ: next fetch wraps to 0x0000_0000.
3. Jump and register jump:
   - At inst_pc=0x3008, npcop=10, imm26=0x0000C10: next fetch at 0x0000_3040.
   - npcop=11, jr_target=0x0040_0102: fetch at 0x0040_0100, addr_err=1 and remains 1 until reset.
4. Stall hold:
   - Stall=1 for 5 cycles in S_VALID, with npcop toggling.
   - Required: inst/inst_pc/inst_valid unchanged, no imem_req, inst_count unchanged.
   - The npcop value in the cycle stall falls to 0 is the one used.
5. Slow memory and timeout:
   - Ack after 3 wait cycles: imem_addr stable throughout, fetch_err=0.
   - No ack for 16 cycles (TIMEOUT=16): fetch_err=1 and stays 1; a later ack still delivers inst normally.
6. Reset mid-fetch:
   - Assert rst while in S_FETCH at pc=0x3020, and drive ack in the same cycle.
   - Required: the ack is ignored, outputs return to reset values, and the first post-reset fetch is at 0x3000.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants for the fetch sequencer (next-PC selects,
//            FSM state encodings, default reset PC).
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] S_RST   = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/fetch_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_if
// Brief    : Instruction-memory request/acknowledge bus.
// Revision : 1.0
// ============================================================================
interface fetch_seq_if;
    import fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/fetch_seq_npc_target.sv
`default_nettype none
// ============================================================================
// Module   : npc_target
// Brief    : Combinational next-PC calculator; returns a word-aligned address
//            and flags when the raw target was misaligned.
// Revision : 1.0
// ============================================================================
module npc_target
    import fetch_pkg::*;
(
    input  wire logic [31:0] pc,
    input  wire logic [1:0]  npcop,
    input  wire logic [15:0] imm16,
    input  wire logic [25:0] imm26,
    input  wire logic [31:0] jr_target,
    output logic      [31:0] next,
    output logic             misaligned
);

    logic [31:0] w_seq;
    logic [31:0] w_raw;

    assign w_seq = pc + 32'd4;

    always_comb begin
        w_raw = w_seq;
        case (npcop)
            NPC_SEQ: w_raw = w_seq;
            NPC_BR:  w_raw = w_seq + {{14{imm16[15]}}, imm16, 2'b00};
            NPC_J:   w_raw = {pc[31:28], imm26, 2'b00};
            NPC_JR:  w_raw = jr_target;
            default: w_raw = w_seq;
        endcase
    end

    // Only a register jump can produce low bits; the fetch still proceeds
    // from the truncated word address.
    assign misaligned = (w_raw[1:0] != 2'b00);
    assign next       = {w_raw[31:2], 2'b00};

endmodule
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Brief    : Program-counter owner; fetches one word per instruction from
//            imem and holds it for decode until consumed.
// Revision : 1.0
// ============================================================================
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 16
)(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [1:0]  npcop,
    input  wire logic [15:0] imm16,
    input  wire logic [25:0] imm26,
    input  wire logic [31:0] jr_target,
    input  wire logic        stall,
    fetch_seq_if.master      imem,
    output logic             inst_valid,
    output logic      [31:0] inst,
    output logic      [31:0] inst_pc,
    output logic      [31:0] inst_count,
    output logic             fetch_err,
    output logic             addr_err
);

    localparam int          c_wait_w   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [31:0]         r_pc;
    logic [31:0]         r_inst;
    logic [31:0]         r_inst_pc;
    logic [31:0]         r_count;
    logic [c_wait_w-1:0] r_wait;
    logic                r_fetch_err;
    logic                r_addr_err;

    logic [31:0]         w_next;
    logic                w_misaligned;

    npc_target u_npc (
        .pc         (r_inst_pc),
        .npcop      (npcop),
        .imm16      (imm16),
        .imm26      (imm26),
        .jr_target  (jr_target),
        .next       (w_next),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RST;
            r_pc        <= RESET_PC;
            r_inst      <= '0;
            r_inst_pc   <= RESET_PC;
            r_count     <= '0;
            r_wait      <= '0;
            r_fetch_err <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            case (r_state)
                S_RST: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        r_inst    <= imem.imem_rdata;
                        r_inst_pc <= r_pc;
                        r_wait    <= '0;
                        r_state   <= S_VALID;
                    end else if (r_wait == c_wait_max) begin
                        // Counter parks at its ceiling; the error is sticky.
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        r_pc    <= w_next;
                        r_count <= r_count + 32'd1;
                        r_state <= S_FETCH;
                        if (w_misaligned) begin
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_RST;
            endcase
        end
    end

    assign imem.imem_req  = (r_state == S_FETCH);
    assign imem.imem_addr = r_pc;
    assign inst_valid     = (r_state == S_VALID);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_count     = r_count;
    assign fetch_err      = r_fetch_err;
    assign addr_err       = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq
// Brief    : Self-checking bench for fetch_seq against a transaction-level
//            model of the PC, instruction stream and sticky flags.
// Revision : 1.0
// ============================================================================
module tb_fetch_seq;

    localparam int c_timeout = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  npcop;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_count;
    logic        fetch_err;
    logic        addr_err;

    fetch_seq_if bus ();

    fetch_seq #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (c_timeout)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .npcop      (npcop),
        .imm16      (imm16),
        .imm26      (imm26),
        .jr_target  (jr_target),
        .stall      (stall),
        .imem       (bus.master),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_count (inst_count),
        .fetch_err  (fetch_err),
        .addr_err   (addr_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_ferr;
    logic        exp_aerr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Next PC straight from the instruction-set rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] op,
                                             input logic [15:0] i16, input logic [25:0] i26,
                                             input logic [31:0] jr);
        int off;
        case (op)
            2'd0:    return p + 32'd4;
            2'd1: begin
                off = int'($signed(i16));
                return p + 32'd4 + 32'(off * 4);
            end
            2'd2:    return (p & 32'hF000_0000) | (32'(i26) * 32'd4);
            default: return jr;
        endcase
    endfunction

    task automatic check_reset_values();
        check("rst_req",   32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid),   32'd0);
        check("rst_inst",  inst,              32'd0);
        check("rst_ipc",   inst_pc,           32'h0000_3000);
        check("rst_cnt",   inst_count,        32'd0);
        check("rst_ferr",  32'(fetch_err),    32'd0);
        check("rst_aerr",  32'(addr_err),     32'd0);
    endtask

    task automatic model_reset();
        exp_pc   = 32'h0000_3000;
        exp_cnt  = 32'd0;
        exp_ferr = 1'b0;
        exp_aerr = 1'b0;
    endtask

    // Entered at a negedge with the DUT in its fetch state; leaves it there.
    task automatic do_instr(input int lat, input int stalls, input logic [1:0] op,
                            input logic [15:0] i16, input logic [25:0] i26,
                            input logic [31:0] jr);
        logic [31:0] nxt;
        check("req_on", 32'(bus.imem_req), 32'd1);
        check("addr",   bus.imem_addr,     exp_pc);
        for (int k = 1; k <= lat; k++) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            stall          = 1'($urandom);
            npcop          = 2'($urandom);
            @(negedge clk);
            check("wait_req",  32'(bus.imem_req),  32'd1);
            check("wait_addr", bus.imem_addr,      exp_pc);
            check("wait_valid", 32'(inst_valid),   32'd0);
            check("wait_ferr", 32'(fetch_err),     32'(exp_ferr || (k >= c_timeout)));
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(exp_pc);
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        if (lat >= c_timeout) exp_ferr = 1'b1;
        check("valid",   32'(inst_valid),   32'd1);
        check("req_off", 32'(bus.imem_req), 32'd0);
        check("inst",    inst,              mem_word(exp_pc));
        check("inst_pc", inst_pc,           exp_pc);
        check("ferr",    32'(fetch_err),    32'(exp_ferr));
        for (int s = 0; s < stalls; s++) begin
            stall     = 1'b1;
            npcop     = 2'($urandom);
            imm16     = 16'($urandom);
            imm26     = 26'($urandom);
            jr_target = $urandom;
            bus.imem_ack = 1'($urandom);
            @(negedge clk);
            bus.imem_ack = 1'b0;
            check("stall_valid", 32'(inst_valid),   32'd1);
            check("stall_req",   32'(bus.imem_req), 32'd0);
            check("stall_inst",  inst,              mem_word(exp_pc));
            check("stall_ipc",   inst_pc,           exp_pc);
            check("stall_cnt",   inst_count,        exp_cnt);
        end
        stall     = 1'b0;
        npcop     = op;
        imm16     = i16;
        imm26     = i26;
        jr_target = jr;
        nxt = ref_next(exp_pc, op, i16, i26, jr);
        if (nxt % 4 != 0) begin
            exp_aerr = 1'b1;
            nxt      = nxt & 32'hFFFF_FFFC;
        end
        @(negedge clk);
        stall = 1'($urandom);
        npcop = 2'($urandom);
        exp_cnt = exp_cnt + 32'd1;
        exp_pc  = nxt;
        check("cons_req",   32'(bus.imem_req), 32'd1);
        check("cons_valid", 32'(inst_valid),   32'd0);
        check("cons_cnt",   inst_count,        exp_cnt);
        check("cons_aerr",  32'(addr_err),     32'(exp_aerr));
        check("cons_ferr",  32'(fetch_err),    32'(exp_ferr));
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        npcop          = 2'd0;
        imm16          = '0;
        imm26          = '0;
        jr_target      = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();
        @(negedge clk);

        // Sequential flow, jump and branch of both signs, wrap, register jump.
        do_instr(0, 0, 2'b00, 16'h0000, 26'h0, 32'h0);
        do_instr(0, 0, 2'b00, 16'h0000, 26'h0, 32'h0);
        do_instr(0, 0, 2'b10, 16'h0000, 26'h0000C10, 32'h0);
        check("cnt_after3", inst_count, 32'd3);
        check("jump_dest",  bus.imem_addr, 32'h0000_3040);
        do_instr(0, 0, 2'b10, 16'h0000, 26'h0000C04, 32'h0);
        do_instr(0, 0, 2'b01, 16'hFFFC, 26'h0, 32'h0);
        check("br_neg", bus.imem_addr, 32'h0000_3004);
        do_instr(0, 0, 2'b10, 16'h0000, 26'h0000C04, 32'h0);
        do_instr(0, 0, 2'b01, 16'h0003, 26'h0, 32'h0);
        check("br_pos", bus.imem_addr, 32'h0000_3020);
        do_instr(0, 0, 2'b11, 16'h0000, 26'h0, 32'hFFFF_FFFC);
        do_instr(0, 0, 2'b00, 16'h0000, 26'h0, 32'h0);
        check("seq_wrap", bus.imem_addr, 32'h0000_0000);
        check("aerr_pre", 32'(addr_err), 32'd0);
        do_instr(0, 0, 2'b11, 16'h0000, 26'h0, 32'h0040_0102);
        check("jr_mis_addr", bus.imem_addr, 32'h0040_0100);
        check("jr_mis_aerr", 32'(addr_err), 32'd1);

        // Stall hold, slow memory, timeout then a late ack.
        do_instr(0, 5, 2'b00, 16'h0000, 26'h0, 32'h0);
        do_instr(3, 0, 2'b00, 16'h0000, 26'h0, 32'h0);
        check("slow_ferr", 32'(fetch_err), 32'd0);
        do_instr(14, 0, 2'b00, 16'h0000, 26'h0, 32'h0);
        check("near_ferr", 32'(fetch_err), 32'd0);
        do_instr(c_timeout + 4, 1, 2'b00, 16'h0000, 26'h0, 32'h0);
        check("to_ferr", 32'(fetch_err), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  op;
            logic [31:0] jr;
            op = 2'($urandom);
            jr = $urandom;
            if ($urandom_range(0, 3) != 0) jr[1:0] = 2'b00;
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), op,
                     16'($urandom), 26'($urandom), jr);
        end

        // Reset in the middle of a fetch at 0x3020 with a coincident ack.
        do_instr(0, 0, 2'b11, 16'h0000, 26'h0, 32'h0000_3020);
        check("mid_addr", bus.imem_addr, 32'h0000_3020);
        rst            = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_values();
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("post_rst_valid", 32'(inst_valid), 32'd0);
        check("post_rst_inst",  inst,            32'd0);
        do_instr(0, 0, 2'b00, 16'h0000, 26'h0, 32'h0);
        check("post_rst_next", bus.imem_addr, 32'h0000_3004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
